// File: rtl/break_scan_scheduler_pkg.sv
// Shared constants, types and helpers for the break-value scan scheduler.
// Optional feature macro: ZERO_BREAK_EARLY_EXIT_EN (stop the scan on a zero break value).
package break_scan_scheduler_pkg;

  localparam int unsigned NUM_LITS    = 3;
  localparam int unsigned VAR_W       = 8;
  localparam int unsigned NUM_CLAUSES = 20;
  localparam int unsigned BV_W        = $clog2(NUM_CLAUSES + 1);
  localparam int unsigned IDX_W       = $clog2(NUM_LITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  typedef logic [BV_W-1:0]  bv_t;
  typedef logic [VAR_W-1:0] var_t;
  typedef logic [IDX_W-1:0] idx_t;

  // First set mask bit at or above 'from'; NUM_LITS when none remains.
  function automatic idx_t next_valid_idx(input logic [NUM_LITS-1:0] mask, input idx_t from);
    idx_t res;
    res = IDX_W'(NUM_LITS);
    for (int i = NUM_LITS - 1; i >= 0; i--) begin
      if ((i >= int'(from)) && mask[i]) res = IDX_W'(i);
    end
    return res;
  endfunction

  function automatic var_t lit_var(input logic [NUM_LITS*VAR_W-1:0] vars, input idx_t idx);
    return vars[int'(idx)*VAR_W +: VAR_W];
  endfunction

endpackage

// File: rtl/break_scan_scheduler_min_break_tracker.sv
// Running minimum of sampled break values; strict less-than keeps the lowest index on ties.
module min_break_tracker
  import break_scan_scheduler_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_sample,
  input  bv_t  i_value,
  input  idx_t i_idx,
  output bv_t  o_next_min,
  output idx_t o_next_idx
);

  bv_t  r_min;
  idx_t r_idx;
  logic r_first;
  logic w_take;

  // The first sample always wins so an all-ones break value is still selectable.
  assign w_take     = i_sample && (r_first || (i_value < r_min));
  assign o_next_min = w_take ? i_value : r_min;
  assign o_next_idx = w_take ? i_idx : r_idx;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_min   <= '1;
      r_idx   <= '0;
      r_first <= 1'b1;
    end else if (w_take) begin
      r_min   <= i_value;
      r_idx   <= i_idx;
      r_first <= 1'b0;
    end
  end

endmodule

// File: rtl/break_scan_scheduler.sv
// Probes each valid literal of a clause for its break value and hands off the minimum.
// Optional feature macro: ZERO_BREAK_EARLY_EXIT_EN.
module break_scan_scheduler
  import break_scan_scheduler_pkg::*;
#(
  parameter int unsigned BV_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  output logic                      ready_o,
  input  logic [NUM_LITS*VAR_W-1:0] lit_vars_i,
  input  logic [NUM_LITS-1:0]       lit_valid_i,
  output logic [VAR_W-1:0]          probe_var_o,
  output logic                      probe_valid_o,
  input  logic [BV_W-1:0]           break_value_i,
  output logic [VAR_W-1:0]          flip_var_o,
  output logic [BV_W-1:0]           min_break_o,
  output logic                      flip_none_o,
  output logic                      flip_valid_o,
  input  logic                      flip_ack_i
);

  localparam int unsigned CNT_W = (BV_LATENCY > 1) ? $clog2(BV_LATENCY) : 1;

  state_t                    r_state;
  logic [NUM_LITS*VAR_W-1:0] r_vars;
  logic [NUM_LITS-1:0]       r_mask;
  idx_t                      r_idx;
  logic [CNT_W-1:0]          r_wait_cnt;

  logic w_accept;
  logic w_sample;
  logic w_exit;
  idx_t w_first_idx;
  idx_t w_next_idx;
  bv_t  w_next_min;
  idx_t w_next_min_idx;

  assign w_accept    = (r_state == S_IDLE) && start_i;
  assign w_sample    = (r_state == S_WAIT) && (r_wait_cnt == CNT_W'(BV_LATENCY - 1));
  assign w_first_idx = next_valid_idx(lit_valid_i, '0);
  assign w_next_idx  = next_valid_idx(r_mask, IDX_W'(r_idx + IDX_W'(1)));

`ifdef ZERO_BREAK_EARLY_EXIT_EN
  assign w_exit = (w_next_idx == IDX_W'(NUM_LITS)) || (break_value_i == '0);
`else
  assign w_exit = (w_next_idx == IDX_W'(NUM_LITS));
`endif

  min_break_tracker u_tracker (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_accept),
    .i_sample   (w_sample),
    .i_value    (break_value_i),
    .i_idx      (r_idx),
    .o_next_min (w_next_min),
    .o_next_idx (w_next_min_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      ready_o       <= 1'b1;
      probe_valid_o <= 1'b0;
      flip_valid_o  <= 1'b0;
      flip_none_o   <= 1'b0;
      probe_var_o   <= '0;
      flip_var_o    <= '0;
      min_break_o   <= '1;
      r_idx         <= '0;
      r_wait_cnt    <= '0;
      r_vars        <= '0;
      r_mask        <= '0;
    end else begin
      probe_valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_vars      <= lit_vars_i;
            r_mask      <= lit_valid_i;
            ready_o     <= 1'b0;
            flip_none_o <= 1'b0;
            if (lit_valid_i == '0) begin
              r_state      <= S_DONE;
              flip_none_o  <= 1'b1;
              flip_var_o   <= '0;
              min_break_o  <= '1;
              flip_valid_o <= 1'b1;
            end else begin
              r_state       <= S_ISSUE;
              r_idx         <= w_first_idx;
              probe_valid_o <= 1'b1;
              probe_var_o   <= lit_var(lit_vars_i, w_first_idx);
            end
          end
        end
        S_ISSUE: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          if (w_sample) begin
            if (w_exit) begin
              r_state      <= S_DONE;
              flip_valid_o <= 1'b1;
              flip_var_o   <= lit_var(r_vars, w_next_min_idx);
              min_break_o  <= w_next_min;
            end else begin
              r_state       <= S_ISSUE;
              r_idx         <= w_next_idx;
              probe_valid_o <= 1'b1;
              probe_var_o   <= lit_var(r_vars, w_next_idx);
            end
          end else begin
            r_wait_cnt <= CNT_W'(r_wait_cnt + 1'b1);
          end
        end
        S_DONE: begin
          if (flip_ack_i) begin
            r_state      <= S_IDLE;
            flip_valid_o <= 1'b0;
            ready_o      <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_break_scan_scheduler.sv
// Directed and randomized scans of break_scan_scheduler against a literal-list reference model.
module tb_break_scan_scheduler;
  import break_scan_scheduler_pkg::*;

  localparam int unsigned TB_LAT = 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start_i;
  logic                      ready_o;
  logic [NUM_LITS*VAR_W-1:0] lit_vars_i;
  logic [NUM_LITS-1:0]       lit_valid_i;
  logic [VAR_W-1:0]          probe_var_o;
  logic                      probe_valid_o;
  logic [BV_W-1:0]           break_value_i;
  logic [VAR_W-1:0]          flip_var_o;
  logic [BV_W-1:0]           min_break_o;
  logic                      flip_none_o;
  logic                      flip_valid_o;
  logic                      flip_ack_i;

  int checks = 0;
  int errors = 0;

  logic [BV_W-1:0] bv_tab [256];
  int              probe_q [$];

  break_scan_scheduler #(.BV_LATENCY(TB_LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .ready_o       (ready_o),
    .lit_vars_i    (lit_vars_i),
    .lit_valid_i   (lit_valid_i),
    .probe_var_o   (probe_var_o),
    .probe_valid_o (probe_valid_o),
    .break_value_i (break_value_i),
    .flip_var_o    (flip_var_o),
    .min_break_o   (min_break_o),
    .flip_none_o   (flip_none_o),
    .flip_valid_o  (flip_valid_o),
    .flip_ack_i    (flip_ack_i)
  );

  always #5 clk = ~clk;

  // Break-value responder: valid exactly one cycle after a probe, garbage otherwise.
  always @(posedge clk) begin
    if (probe_valid_o) begin
      probe_q.push_back(int'(probe_var_o));
      break_value_i <= bv_tab[probe_var_o];
    end else begin
      break_value_i <= BV_W'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: probe the valid literals in order, keep the first strictly smaller value.
  task automatic model(input int vars[NUM_LITS], input logic [NUM_LITS-1:0] mask,
                       output int exp_probes[$], output int exp_var, output int exp_min,
                       output int exp_none, output int exp_lat);
    int best;
    exp_probes = {};
    best = -1;
    exp_var = 0;
    exp_min = (1 << BV_W) - 1;
    exp_none = (mask == '0) ? 1 : 0;
    for (int j = 0; j < NUM_LITS; j++) begin
      if (mask[j]) begin
        exp_probes.push_back(vars[j]);
        if (best < 0 || int'(bv_tab[vars[j]]) < best) begin
          best = int'(bv_tab[vars[j]]);
          exp_var = vars[j];
          exp_min = best;
        end
`ifdef ZERO_BREAK_EARLY_EXIT_EN
        if (bv_tab[vars[j]] == '0) break;
`endif
      end
    end
    exp_lat = 1 + exp_probes.size() * (TB_LAT + 1);
  endtask

  task automatic run_scan(input string tag, input int vars[NUM_LITS],
                          input logic [NUM_LITS-1:0] mask, input int hold);
    int exp_probes[$];
    int exp_var, exp_min, exp_none, exp_lat, n;
    model(vars, mask, exp_probes, exp_var, exp_min, exp_none, exp_lat);
    probe_q = {};
    for (int j = 0; j < NUM_LITS; j++) lit_vars_i[j*VAR_W +: VAR_W] = VAR_W'(vars[j]);
    lit_valid_i = mask;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    lit_vars_i = {NUM_LITS{VAR_W'($urandom)}};
    lit_valid_i = NUM_LITS'($urandom);
    check({tag, " ready_low"}, 32'(ready_o), 0);
    n = 1;
    while (!flip_valid_o && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " flip_var"}, 32'(flip_var_o), exp_var);
    check({tag, " min_break"}, 32'(min_break_o), exp_min);
    check({tag, " flip_none"}, 32'(flip_none_o), exp_none);
    check({tag, " probe_count"}, probe_q.size(), exp_probes.size());
    for (int k = 0; k < exp_probes.size() && k < probe_q.size(); k++)
      check({tag, " probe_var"}, probe_q[k], exp_probes[k]);
    for (int h = 0; h < hold; h++) begin
      start_i = 1'b1;
      lit_valid_i = '1;
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold_valid"}, 32'(flip_valid_o), 1);
      check({tag, " hold_var"}, 32'(flip_var_o), exp_var);
      check({tag, " hold_min"}, 32'(min_break_o), exp_min);
      check({tag, " hold_probe"}, 32'(probe_valid_o), 0);
    end
    start_i = 1'b1;
    flip_ack_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flip_ack_i = 1'b0;
    start_i = 1'b0;
    check({tag, " ack_ready"}, 32'(ready_o), 1);
    check({tag, " ack_valid"}, 32'(flip_valid_o), 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " idle_ready"}, 32'(ready_o), 1);
    check({tag, " idle_probe"}, 32'(probe_valid_o), 0);
  endtask

  initial begin
    int v[NUM_LITS];
    int vr[NUM_LITS];
    logic [NUM_LITS-1:0] m;
    for (int i = 0; i < 256; i++) bv_tab[i] = BV_W'($urandom);
    reset = 1'b1;
    start_i = 1'b0;
    flip_ack_i = 1'b0;
    lit_vars_i = '0;
    lit_valid_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ready", 32'(ready_o), 1);
    check("rst probe_valid", 32'(probe_valid_o), 0);
    check("rst flip_valid", 32'(flip_valid_o), 0);
    check("rst flip_none", 32'(flip_none_o), 0);
    check("rst probe_var", 32'(probe_var_o), 0);
    check("rst flip_var", 32'(flip_var_o), 0);
    check("rst min", 32'(min_break_o), (1 << BV_W) - 1);
    reset = 1'b0;
    @(negedge clk);

    v = '{5, 9, 12};
    bv_tab[5] = 3; bv_tab[9] = 1; bv_tab[12] = 2;
    run_scan("basic", v, 3'b111, 0);
    bv_tab[5] = 2; bv_tab[9] = 2; bv_tab[12] = 4;
    run_scan("tie", v, 3'b111, 1);
    bv_tab[5] = 4; bv_tab[9] = 0; bv_tab[12] = 0;
    run_scan("mask101", v, 3'b101, 0);
    run_scan("mask000", v, 3'b000, 2);
    bv_tab[5] = '1; bv_tab[9] = '1; bv_tab[12] = '1;
    run_scan("allones", v, 3'b110, 0);
    bv_tab[5] = 0; bv_tab[9] = 1; bv_tab[12] = 1;
    run_scan("zero_first", v, 3'b111, 4);

    // Reset during the WAIT cycle of the second probe.
    for (int j = 0; j < NUM_LITS; j++) lit_vars_i[j*VAR_W +: VAR_W] = VAR_W'(v[j]);
    lit_valid_i = 3'b111;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst ready", 32'(ready_o), 1);
    check("midrst flip_valid", 32'(flip_valid_o), 0);
    check("midrst probe_var", 32'(probe_var_o), 0);
    check("midrst min", 32'(min_break_o), (1 << BV_W) - 1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst no_flip", 32'(flip_valid_o), 0);
    end
    bv_tab[5] = 3; bv_tab[9] = 1; bv_tab[12] = 2;
    run_scan("after_rst", v, 3'b111, 0);

    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j < NUM_LITS; j++) begin
        vr[j] = int'($urandom_range(0, 255));
        bv_tab[vr[j]] = ($urandom_range(0, 1) == 0) ? BV_W'($urandom_range(0, 3))
                                                     : BV_W'($urandom);
      end
      m = NUM_LITS'($urandom);
      run_scan("rand", vr, m, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/break_scan_scheduler.md
Name: break_scan_scheduler

Overview:
- Sequences the combinational break-value counter across the candidate literals of one selected unsatisfied clause, one literal per probe.
- Latches the clause's variable list, issues one probe per valid literal, and samples the returned break value.
- Tracks the minimum and hands the chosen flip variable to the flip/assignment stage over a valid/ack handshake.
- Sits between the unsat-clause selector and the variable-flip logic.

Parameters:
- NUM_LITS, 3, max literals per clause (k of k-SAT).
- VAR_W, 8, variable index width.
- NUM_CLAUSES, 20, clauses per variable in the clause table; sets the break-value width.
- BV_W, $clog2(NUM_CLAUSES+1), break-value width (shared package constant). Narrower upstream values are zero-extended.
- BV_LATENCY, 1, cycles from probe_valid_o to a valid break_value_i; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  start a scan; accepted only when ready_o=1
- ready_o  out  1  high only in IDLE
- lit_vars_i  in  NUM_LITS*VAR_W  candidate variable indices; literal j occupies bits [j*VAR_W +: VAR_W]; captured on accept
- lit_valid_i  in  NUM_LITS  per-literal valid mask; captured on accept
- probe_var_o  out  VAR_W  variable whose break value is being requested
- probe_valid_o  out  1  one-cycle pulse per probe
- break_value_i  in  BV_W  break value for the current probe; sampled exactly BV_LATENCY cycles after the probe
- flip_var_o  out  VAR_W  selected variable
- min_break_o  out  BV_W  break value of the selected variable
- flip_none_o  out  1  set when the captured mask had no valid literal
- flip_valid_o  out  1  result valid; held until acked
- flip_ack_i  in  1  consumer accepts the result

Behaviour:
- Reset values:
  - State IDLE, ready_o=1.
  - probe_valid_o=0, flip_valid_o=0, flip_none_o=0.
  - probe_var_o=0, flip_var_o=0.
  - min_break_o = all ones.
  - Internal index and wait counter = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On start_i at cycle T: capture lit_vars_i/lit_valid_i, set the running min to all ones, clear flip_none_o.
  - Go to ISSUE at the first valid index.
  - If the mask is 0: go to DONE with flip_none_o=1 and flip_var_o=0.
- ISSUE: one cycle; probe_valid_o=1, probe_var_o = captured var[idx]; go to WAIT.
- WAIT:
  - Counts BV_LATENCY cycles, then samples break_value_i on the last WAIT cycle.
  - Min update uses strict less-than: on ties the lower index wins.
  - After the sample, go to ISSUE at the next valid index, or to DONE if none remains. Invalid indices are skipped with zero cycles spent on them.
- Timing per valid literal: BV_LATENCY+1 cycles.
  - With BV_LATENCY=1 and 3 valid literals: probes at T+1, T+3, T+5; samples at T+2, T+4, T+6; flip_valid_o=1 from T+7.
- DONE:
  - flip_valid_o=1; flip_var_o, min_break_o and flip_none_o are stable.
  - On flip_ack_i: go to IDLE next cycle; ready_o=1 and flip_valid_o=0 in that cycle.
  - start_i is ignored while in DONE, including in the ack cycle.
- probe_var_o holds its last value outside ISSUE. Only probe_valid_o qualifies it.
- Reset asserted mid-scan: returns to IDLE next edge with all reset values applied. No partial result is emitted.
- start_i while ready_o=0: ignored, not queued.
- lit_* changes after the accept cycle have no effect on the current scan.
- A break value of all ones is still a legal candidate. The first valid literal always replaces the initial min.

Optional Feature:
- ZERO_BREAK_EARLY_EXIT_EN, defined:
  - A sampled break value of 0 selects that literal immediately and goes straight to DONE. Remaining literals are not probed.
  - flip_valid_o rises the cycle after that sample.
- Not defined: all valid literals are always probed; the result is identical except for latency.

Decomposition:
- Shared package:
  - BV_W and VAR_W constants.
  - State enum (IDLE/ISSUE/WAIT/DONE).
  - Break-value and variable-index typedefs.
  - Function returning the next valid index from a mask and a current index.
- One sub-module: min_break_tracker, holding the running min register, the index of the min, and the strict-less compare/update.
- The FSM and the latency counter stay in the top module.

Test Plan:
- Vars {5,9,12}, mask 111, break values {3,1,2}, BV_LATENCY=1 -> flip_var_o=9, min_break_o=1, flip_valid_o at T+7, exactly 3 probe pulses.
- Break values {2,2,4} -> tie resolves to the lower index: flip_var_o=5, min_break_o=2.
- Mask 101 with vars {5,9,12}, break values {4,x,0} -> only vars 5 and 12 are probed; flip_var_o=12, min 0, flip_valid_o at T+5.
- Mask 000 -> no probes; flip_none_o=1, flip_valid_o at T+1; ack returns to IDLE.
- Reset asserted in WAIT of the second probe -> IDLE next cycle, flip_valid_o never rises; a new start then completes normally.
- ZERO_BREAK_EARLY_EXIT_EN defined, break values {0,1,1} -> one probe only; flip_var_o=5, flip_valid_o at T+3. Hold flip_ack_i low for 4 cycles: outputs stay stable and start_i pulses are ignored.
